// File: rtl/nn_sample_feeder.sv
// rtl/nn_sample_feeder.sv - buffers host sample vectors and runs each through the network core
// with a fixed init/write_reg/start handshake, returning one result per sample in order.
module nn_sample_feeder #(
   parameter int DATA_W  = 32,
   parameter int IDX_W   = 16,
   parameter int DEPTH   = 8,
   parameter int TIMEOUT = 1024
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    enable_i,
   input  logic                    in_valid_i,
   output logic                    in_ready_o,
   input  logic [DATA_W-1:0]       in_x1_i,
   input  logic [DATA_W-1:0]       in_x2_i,
   input  logic [DATA_W-1:0]       in_x3_i,
   input  logic [DATA_W-1:0]       in_x4_i,
   output logic [DATA_W-1:0]       x1_o,
   output logic [DATA_W-1:0]       x2_o,
   output logic [DATA_W-1:0]       x3_o,
   output logic [DATA_W-1:0]       x4_o,
   output logic                    init_o,
   output logic                    write_reg_o,
   output logic                    start_o,
   input  logic                    done_i,
   input  logic [IDX_W-1:0]        max_index_i,
   output logic                    res_valid_o,
   input  logic                    res_ready_i,
   output logic [IDX_W-1:0]        res_index_o,
   output logic                    res_timeout_o,
   output logic                    busy_o,
   output logic [$clog2(DEPTH):0]  level_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(TIMEOUT);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT-1);

   typedef enum logic [2:0] {
      S_IDLE, S_INIT, S_LOAD, S_START, S_WAIT, S_EMIT
   } state_t;

   state_t                 state_q;
   logic [4*DATA_W-1:0]    mem_q [DEPTH];
   logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
   logic [AW:0]            level_q, level_d;
   logic [TW-1:0]          timer_q;
   logic [DATA_W-1:0]      x1_q, x2_q, x3_q, x4_q;
   logic                   init_q, write_reg_q, start_q;
   logic                   res_valid_q, res_timeout_q;
   logic [IDX_W-1:0]       res_index_q;
   logic                   push, pop;

   // Ready comes from the registered level, so a same-cycle pop never frees a slot early.
   assign in_ready_o = (level_q != FULL_LVL);
   assign push       = in_valid_i && in_ready_o;
   assign pop        = (state_q == S_IDLE) && enable_i && (level_q != '0);

   always_comb begin
      level_d = level_q;
      case ({push, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         level_q <= level_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= {in_x1_i, in_x2_i, in_x3_i, in_x4_i};
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= S_IDLE;
         x1_q          <= '0;
         x2_q          <= '0;
         x3_q          <= '0;
         x4_q          <= '0;
         init_q        <= 1'b0;
         write_reg_q   <= 1'b0;
         start_q       <= 1'b0;
         res_valid_q   <= 1'b0;
         res_timeout_q <= 1'b0;
         res_index_q   <= '0;
         timer_q       <= '0;
      end else begin
         init_q      <= 1'b0;
         write_reg_q <= 1'b0;
         start_q     <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (pop) begin
                  state_q <= S_INIT;
                  init_q  <= 1'b1;
                  {x1_q, x2_q, x3_q, x4_q} <= mem_q[rd_ptr_q];
               end
            end
            S_INIT: begin
               state_q     <= S_LOAD;
               write_reg_q <= 1'b1;
            end
            S_LOAD: begin
               state_q <= S_START;
               start_q <= 1'b1;
            end
            S_START: begin
               state_q <= S_WAIT;
               timer_q <= '0;
            end
            S_WAIT: begin
               // done takes priority over a timeout landing in the same cycle
               if (done_i) begin
                  state_q       <= S_EMIT;
                  res_valid_q   <= 1'b1;
                  res_index_q   <= max_index_i;
                  res_timeout_q <= 1'b0;
               end else if (timer_q == TMO_LAST) begin
                  state_q       <= S_EMIT;
                  res_valid_q   <= 1'b1;
                  res_index_q   <= '1;
                  res_timeout_q <= 1'b1;
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end
            S_EMIT: begin
               if (res_ready_i) begin
                  state_q     <= S_IDLE;
                  res_valid_q <= 1'b0;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign x1_o          = x1_q;
   assign x2_o          = x2_q;
   assign x3_o          = x3_q;
   assign x4_o          = x4_q;
   assign init_o        = init_q;
   assign write_reg_o   = write_reg_q;
   assign start_o       = start_q;
   assign res_valid_o   = res_valid_q;
   assign res_index_o   = res_index_q;
   assign res_timeout_o = res_timeout_q;
   assign busy_o        = (state_q != S_IDLE);
   assign level_o       = level_q;

endmodule

// File: tb/tb_nn_sample_feeder.sv
// tb/tb_nn_sample_feeder.sv - randomized scoreboard bench for nn_sample_feeder
module tb_nn_sample_feeder;
   localparam int DATA_W  = 32;
   localparam int IDX_W   = 16;
   localparam int DEPTH   = 8;
   localparam int TIMEOUT = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                   rst_i, enable_i, in_valid_i, in_ready_o;
   logic [DATA_W-1:0]      in_x1_i, in_x2_i, in_x3_i, in_x4_i;
   logic [DATA_W-1:0]      x1_o, x2_o, x3_o, x4_o;
   logic                   init_o, write_reg_o, start_o, done_i;
   logic [IDX_W-1:0]       max_index_i, res_index_o;
   logic                   res_valid_o, res_ready_i, res_timeout_o, busy_o;
   logic [$clog2(DEPTH):0] level_o;

   nn_sample_feeder #(.DATA_W(DATA_W), .IDX_W(IDX_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .in_x1_i(in_x1_i), .in_x2_i(in_x2_i), .in_x3_i(in_x3_i), .in_x4_i(in_x4_i),
      .x1_o(x1_o), .x2_o(x2_o), .x3_o(x3_o), .x4_o(x4_o),
      .init_o(init_o), .write_reg_o(write_reg_o), .start_o(start_o),
      .done_i(done_i), .max_index_i(max_index_i),
      .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
      .res_index_o(res_index_o), .res_timeout_o(res_timeout_o),
      .busy_o(busy_o), .level_o(level_o)
   );

   typedef struct { logic [IDX_W-1:0] idx; logic tmo; int rise; } res_t;
   typedef struct { logic [DATA_W-1:0] a, b, c, d; } smp_t;

   res_t exp_res[$];
   smp_t exp_smp[$];
   int   forced_d[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   core_cnt = -1;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(input string name, input longint act, input longint req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endfunction

   // Network core model: picks a response delay at each start; done is random noise outside WAIT.
   initial begin : core
      int d;
      logic [IDX_W-1:0] idx;
      res_t r;
      d = 0; idx = '0;
      done_i = 1'b0; max_index_i = '0;
      forever begin
         @(posedge clk); #2;
         if (rst_i) begin
            core_cnt = -1;
            done_i   = 1'b0;
         end else begin
            if (core_cnt >= 0) begin
               done_i      = (core_cnt == d);
               max_index_i = (core_cnt == d) ? idx : IDX_W'($urandom);
               core_cnt++;
               if (core_cnt > d || core_cnt >= TIMEOUT) core_cnt = -1;
            end else begin
               done_i      = ($urandom_range(0, 3) == 0);
               max_index_i = IDX_W'($urandom);
            end
            if (start_o) begin
               d   = (forced_d.size() > 0) ? forced_d.pop_front() : int'($urandom_range(0, TIMEOUT + 4));
               idx = IDX_W'($urandom_range(0, 16'hFFFE));
               core_cnt = 0;
               if (d < TIMEOUT) begin
                  r.idx = idx; r.tmo = 1'b0; r.rise = cyc + 2 + d;
               end else begin
                  r.idx = '1;  r.tmo = 1'b1; r.rise = cyc + 1 + TIMEOUT;
               end
               exp_res.push_back(r);
            end
         end
      end
   end

   initial begin : ready_gen
      res_ready_i = 1'b0;
      forever begin
         @(posedge clk); #1;
         res_ready_i = ($urandom_range(0, 3) == 0);
      end
   end

   initial begin : monitor
      logic pv, pr, ptmo, idle_now, want, in_flight;
      logic [IDX_W-1:0] pidx;
      int init_cyc;
      smp_t cur, s;
      res_t r;
      pv = 0; pr = 0; ptmo = 0; pidx = '0; want = 0; in_flight = 0; init_cyc = 0;
      cur.a = '0; cur.b = '0; cur.c = '0; cur.d = '0;
      forever begin
         @(negedge clk);
         if (rst_i) begin
            exp_smp.delete(); exp_res.delete();
            pv = 0; pr = 0; in_flight = 0; want = 0;
            continue;
         end
         idle_now = !in_flight && !init_o;
         check("launch", longint'(init_o), longint'(want));
         if (init_o || write_reg_o || start_o)
            check("one_pulse", longint'(init_o) + longint'(write_reg_o) + longint'(start_o), 1);
         if (init_o) begin
            check("init_in_flight", longint'(in_flight), 0);
            in_flight = 1; init_cyc = cyc;
            check("launch_has_sample", longint'(exp_smp.size() > 0), 1);
            if (exp_smp.size() > 0) cur = exp_smp.pop_front();
         end
         if (write_reg_o) begin
            check("wr_timing", cyc, init_cyc + 1);
            check("x1", longint'(x1_o), longint'(cur.a));
            check("x2", longint'(x2_o), longint'(cur.b));
            check("x3", longint'(x3_o), longint'(cur.c));
            check("x4", longint'(x4_o), longint'(cur.d));
         end
         if (start_o) check("start_timing", cyc, init_cyc + 2);
         check("level", longint'(level_o), longint'(exp_smp.size()));
         check("in_ready", longint'(in_ready_o), longint'(exp_smp.size() != DEPTH));
         check("busy", longint'(busy_o), longint'(in_flight));
         if (res_valid_o && !pv) begin
            check("res_has_expect", longint'(exp_res.size() > 0), 1);
            if (exp_res.size() > 0) check("res_latency", cyc, exp_res[0].rise);
         end
         if (pv && !pr) begin
            check("res_hold_valid", longint'(res_valid_o), 1);
            check("res_hold_idx", longint'(res_index_o), longint'(pidx));
            check("res_hold_tmo", longint'(res_timeout_o), longint'(ptmo));
         end
         if (res_valid_o && res_ready_i && exp_res.size() > 0) begin
            r = exp_res.pop_front();
            check("res_index", longint'(res_index_o), longint'(r.idx));
            check("res_timeout", longint'(res_timeout_o), longint'(r.tmo));
            check("x_hold", longint'(x1_o ^ x4_o), longint'(cur.a ^ cur.d));
            in_flight = 0;
         end
         pv = res_valid_o; pr = res_ready_i; pidx = res_index_o; ptmo = res_timeout_o;
         want = idle_now && enable_i && (exp_smp.size() > 0);
         if (in_valid_i && in_ready_o) begin
            s.a = in_x1_i; s.b = in_x2_i; s.c = in_x3_i; s.d = in_x4_i;
            exp_smp.push_back(s);
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic push_one(output bit ok);
      in_valid_i = 1'b1;
      in_x1_i = $urandom; in_x2_i = $urandom; in_x3_i = $urandom; in_x4_i = $urandom;
      ok = 0;
      for (int t = 0; t < 400 && !ok; t++) begin
         @(negedge clk);
         ok = in_ready_o;
         @(posedge clk); #1;
      end
      in_valid_i = 1'b0;
   endtask

   task automatic drain(input string name);
      int t;
      t = 0;
      while ((busy_o || level_o != 0) && t < 3000) begin
         @(posedge clk); #1;
         t++;
      end
      check({name, "_drain_busy"}, longint'(busy_o), 0);
      check({name, "_drain_level"}, longint'(level_o), 0);
      check({name, "_drain_resq"}, longint'(exp_res.size()), 0);
   endtask

   initial begin : main
      bit ok;
      int t;
      rst_i = 1'b1; enable_i = 1'b0; in_valid_i = 1'b0;
      in_x1_i = '0; in_x2_i = '0; in_x3_i = '0; in_x4_i = '0;
      repeat (3) @(posedge clk);
      #1 rst_i = 1'b0;
      @(negedge clk);
      check("rst_level", longint'(level_o), 0);
      check("rst_in_ready", longint'(in_ready_o), 1);
      check("rst_busy", longint'(busy_o), 0);
      check("rst_res_valid", longint'(res_valid_o), 0);
      check("rst_res_index", longint'(res_index_o), 0);
      check("rst_res_timeout", longint'(res_timeout_o), 0);
      check("rst_x", longint'(x1_o | x2_o | x3_o | x4_o), 0);
      check("rst_pulses", longint'(init_o | write_reg_o | start_o), 0);

      // fill the FIFO with launching blocked; the ninth offer must be refused
      @(posedge clk); #1;
      for (int i = 0; i < DEPTH + 1; i++) begin
         in_valid_i = 1'b1;
         in_x1_i = $urandom; in_x2_i = $urandom; in_x3_i = $urandom; in_x4_i = $urandom;
         @(posedge clk); #1;
      end
      in_valid_i = 1'b0;
      @(negedge clk);
      check("full_level", longint'(level_o), DEPTH);
      check("full_in_ready", longint'(in_ready_o), 0);
      @(posedge clk); #1;
      enable_i = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("unfull_level", longint'(level_o), DEPTH - 1);
      check("unfull_in_ready", longint'(in_ready_o), 1);
      drain("full");

      forced_d.delete();
      forced_d.push_back(TIMEOUT - 1);
      forced_d.push_back(0);
      forced_d.push_back(TIMEOUT);
      forced_d.push_back(TIMEOUT - 2);
      forced_d.push_back(TIMEOUT + 3);
      forced_d.push_back(1);
      for (int i = 0; i < 40; i++) begin
         push_one(ok);
         check("push_accepted", longint'(ok), 1);
         enable_i = ($urandom_range(0, 7) != 0);
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
         end
         enable_i = 1'b1;
      end
      drain("rand");

      // reset while a sample sits in WAIT with three more queued
      forced_d.delete();
      forced_d.push_back(TIMEOUT + 10);
      enable_i = 1'b0;
      repeat (4) begin
         push_one(ok);
         check("mr_push", longint'(ok), 1);
      end
      enable_i = 1'b1;
      t = 0;
      while (!(core_cnt >= 2 && level_o == 3) && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      check("mr_wait_level", longint'(level_o), 3);
      check("mr_wait_busy", longint'(busy_o), 1);
      rst_i = 1'b1;
      @(posedge clk); #1;
      rst_i = 1'b0;
      @(negedge clk);
      check("mr_level", longint'(level_o), 0);
      check("mr_busy", longint'(busy_o), 0);
      check("mr_x", longint'(x1_o | x2_o | x3_o | x4_o), 0);
      check("mr_res_valid", longint'(res_valid_o), 0);
      repeat (40) @(posedge clk);
      #1;
      check("mr_no_result", longint'(res_valid_o), 0);
      check("mr_resq", longint'(exp_res.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/nn_sample_feeder.md
Name: nn_sample_feeder

Overview:
Initiator side of the network core's sample interface. It drives x1..x4, init, write_reg and start, and consumes done and max_index. Sample vectors arrive from a host stream and are buffered in a FIFO. Each vector is run through the network by a fixed init -> write_reg -> start sequence. Each resulting winner index, or a timeout marker, is returned on a valid/ready result port in FIFO order.

Parameters:
DATA_W, 32, width of each sample element x1..x4
IDX_W, 16, width of max_index / res_index
DEPTH, 8, sample FIFO entries (power of 2, >=2)
TIMEOUT, 1024, max cycles in WAIT before the sample is abandoned (>=2)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
enable  in  1  when 0, no new sample is launched; an in-flight sample completes normally
in_valid  in  1  host sample valid
in_ready  out  1  = (level != DEPTH)
in_x1..in_x4  in  DATA_W each  host sample elements
x1..x4  out  DATA_W each  registered sample to network core
init  out  1  one-cycle pulse, network init
write_reg  out  1  one-cycle pulse, network latches x1..x4
start  out  1  one-cycle pulse, network start
done  in  1  network completion, sampled only in WAIT
max_index  in  IDX_W  network result, captured when done=1 in WAIT
res_valid  out  1  result available
res_ready  in  1  result consumer ready
res_index  out  IDX_W  captured max_index, or all-ones on timeout
res_timeout  out  1  result was produced by timeout
busy  out  1  FSM not in IDLE
level  out  clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst=1 at an edge): FSM=IDLE; FIFO flushed (level=0); x1..x4=0; init, write_reg, start, res_valid, res_timeout = 0; res_index=0; busy=0; timer=0. Reset mid-operation discards the in-flight sample and any pending result. No pulses are emitted in the cycle after reset.
- FIFO push: on in_valid && in_ready. Pop occurs only on the IDLE->INIT transition.
  - in_ready is derived from the registered level, so a push is refused when full even if a pop happens in the same cycle.
  - Push and pop in the same cycle with level<DEPTH leaves level unchanged.
  - Read/write pointers wrap modulo DEPTH.
- FSM, one state per cycle unless noted:
  - IDLE: if enable && level!=0 -> INIT. At this edge, x1..x4 are loaded from the FIFO head and the FIFO pops.
  - INIT: init=1 -> LOAD.
  - LOAD: write_reg=1 -> START.
  - START: start=1; timer cleared -> WAIT.
  - WAIT:
    - done=1 -> EMIT; res_index<=max_index, res_timeout<=0.
    - Else, if timer==TIMEOUT-1 -> EMIT; res_index<=all-ones, res_timeout<=1.
    - Else timer++.
    - If done and timeout occur in the same cycle, done wins.
  - EMIT: res_valid=1; res_index and res_timeout stable until accepted. On res_ready -> IDLE, and res_valid drops at that edge.
- Latency:
  - IDLE->INIT edge at cycle k.
  - init high in cycle k+1, write_reg in k+2, start in k+3.
  - done is first sampled in cycle k+4.
  - A done seen in cycle n gives res_valid high from cycle n+1.
  - A sample pushed into an empty FIFO in cycle p (FSM idle, enable=1) gives init high in cycle p+2.
- x1..x4 hold their value from the launch edge through EMIT; they change only at the next launch.
- done and max_index are ignored outside WAIT, including a stale done during INIT/LOAD/START.
- At most one pulse among init/write_reg/start is high in any cycle; each is high for exactly one cycle per sample.
- Only one sample is in flight at a time. The next launch requires the previous result to be accepted.
- enable=0 blocks only the IDLE->INIT transition. FIFO pushes continue.

Test Plan:
- Single sample: push (1,2,3,4) into an empty FIFO idle at cycle 0 -> init@2, write_reg@3, start@4, x1..x4=1,2,3,4. Drive done=1, max_index=16'h0002 at cycle 10 -> res_valid@11, res_index=0002, res_timeout=0. res_ready@13 -> busy drops at 14.
- Ordering/backpressure: push 3 samples with results 5, 7, 9 and hold res_ready=0 for 20 cycles per result -> results return in order 5, 7, 9. No second init before each result is accepted. level decrements by one per launch.
- Full FIFO: enable=0, push 9 samples with DEPTH=8 -> in_ready=0 once level=8; 9th sample not accepted; level stays 8. Set enable=1 -> first launch pops and in_ready returns high next cycle.
- Timeout: TIMEOUT=16, never assert done -> EMIT entered 16 cycles after the first WAIT cycle with res_index=16'hFFFF, res_timeout=1. Then done=1 while in EMIT/IDLE is ignored.
- Done/timeout collision: done=1 with max_index=3 exactly in the timer==TIMEOUT-1 cycle -> res_index=3, res_timeout=0. Spurious done during INIT -> ignored; the FSM still waits for done in WAIT.
- Reset mid-run: rst=1 while in WAIT with level=3 -> next cycle level=0, busy=0, x1..x4=0, res_valid=0. A later done produces no result.
